// File: rtl/dport_axi_tcm_pkg.sv
// Shared constants and helpers for the dport_axi_tcm AXI4 scratch memory.
package dport_axi_tcm_pkg;

  localparam int unsigned AXI_ID_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // True when the byte address has bits set above the RAM's word-index range.
  function automatic logic upper_bits_set(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) != '0;
  endfunction

endpackage

// File: rtl/dport_axi_tcm_ram.sv
// Word-wide RAM: one byte-enabled write port, one registered read port.
// A read and a write to the same word in the same cycle returns the old data.
module dport_axi_tcm_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [3:0]        wr_strb_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes and registered read; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) begin
          mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/dport_axi_tcm.sv
// AXI4 single-beat responder backed by a local word-wide TCM.
// Optional: define DPORT_AXI_TCM_ERR_EN to answer out-of-range addresses with
// SLVERR (writes dropped, reads return zero); otherwise upper bits alias.
module dport_axi_tcm
  import dport_axi_tcm_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                axi_awvalid_i,
  input  logic [31:0]         axi_awaddr_i,
  input  logic [AXI_ID_W-1:0] axi_awid_i,
  output logic                axi_awready_o,
  input  logic                axi_wvalid_i,
  input  logic [31:0]         axi_wdata_i,
  input  logic [3:0]          axi_wstrb_i,
  output logic                axi_wready_o,
  output logic                axi_bvalid_o,
  output logic [1:0]          axi_bresp_o,
  output logic [AXI_ID_W-1:0] axi_bid_o,
  input  logic                axi_bready_i,
  input  logic                axi_arvalid_i,
  input  logic [31:0]         axi_araddr_i,
  input  logic [AXI_ID_W-1:0] axi_arid_i,
  output logic                axi_arready_o,
  output logic                axi_rvalid_o,
  output logic [31:0]         axi_rdata_o,
  output logic [1:0]          axi_rresp_o,
  output logic [AXI_ID_W-1:0] axi_rid_o,
  output logic                axi_rlast_o,
  input  logic                axi_rready_i
);

  logic                aw_held, w_held;
  logic [31:0]         aw_addr_q;
  logic [AXI_ID_W-1:0] aw_id_q;
  logic [31:0]         w_data_q;
  logic [3:0]          w_strb_q;
  logic                rd_zero_q;

  logic                aw_fire, w_fire, ar_fire, do_write;
  logic [31:0]         wr_addr_sel, wr_data_sel;
  logic [3:0]          wr_strb_sel;
  logic [AXI_ID_W-1:0] wr_id_sel;
  logic                wr_err, rd_err;
  logic [31:0]         ram_rdata;
  logic                unused_addr_bits;

  assign axi_awready_o = !rst_i && !aw_held && !axi_bvalid_o;
  assign axi_wready_o  = !rst_i && !w_held && !axi_bvalid_o;
  assign axi_arready_o = !rst_i && (!axi_rvalid_o || axi_rready_i);
  assign axi_rlast_o   = 1'b1;

  assign aw_fire  = axi_awvalid_i && axi_awready_o;
  assign w_fire   = axi_wvalid_i && axi_wready_o;
  assign ar_fire  = axi_arvalid_i && axi_arready_o;
  assign do_write = (aw_held || aw_fire) && (w_held || w_fire);

  // A held slot takes priority; otherwise the live handshake supplies the beat.
  always_comb begin
    wr_addr_sel = aw_held ? aw_addr_q : axi_awaddr_i;
    wr_id_sel   = aw_held ? aw_id_q   : axi_awid_i;
    wr_data_sel = w_held  ? w_data_q  : axi_wdata_i;
    wr_strb_sel = w_held  ? w_strb_q  : axi_wstrb_i;
  end

`ifdef DPORT_AXI_TCM_ERR_EN
  assign wr_err = upper_bits_set(wr_addr_sel, ADDR_W);
  assign rd_err = upper_bits_set(axi_araddr_i, ADDR_W);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Byte-offset and (when aliasing) upper address bits are intentionally dropped.
  assign unused_addr_bits = ^{wr_addr_sel, axi_araddr_i};

  dport_axi_tcm_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (do_write && !wr_err),
    .wr_addr_i (wr_addr_sel[ADDR_W+1:2]),
    .wr_data_i (wr_data_sel),
    .wr_strb_i (wr_strb_sel),
    .rd_en_i   (ar_fire),
    .rd_addr_i (axi_araddr_i[ADDR_W+1:2]),
    .rd_data_o (ram_rdata)
  );

  // Write path: AW/W holding slots, merge into one RAM write, then a single B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      axi_bvalid_o <= 1'b0;
      axi_bresp_o  <= AXI_RESP_OKAY;
      axi_bid_o    <= '0;
    end else if (do_write) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      axi_bvalid_o <= 1'b1;
      axi_bid_o    <= wr_id_sel;
      axi_bresp_o  <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi_awaddr_i;
        aw_id_q   <= axi_awid_i;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= axi_wdata_i;
        w_strb_q <= axi_wstrb_i;
      end
      if (axi_bvalid_o && axi_bready_i) begin
        axi_bvalid_o <= 1'b0;
      end
    end
  end

  // Read path: one-cycle registered response, held while the master stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      axi_rvalid_o <= 1'b0;
      axi_rid_o    <= '0;
      axi_rresp_o  <= AXI_RESP_OKAY;
      rd_zero_q    <= 1'b1;
    end else if (ar_fire) begin
      axi_rvalid_o <= 1'b1;
      axi_rid_o    <= axi_arid_i;
      axi_rresp_o  <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      rd_zero_q    <= rd_err;
    end else if (axi_rready_i) begin
      axi_rvalid_o <= 1'b0;
    end
  end

  // RAM read data is unreset, so zero is forced after reset and for erroring reads.
  assign axi_rdata_o = rd_zero_q ? '0 : ram_rdata;

endmodule
